// File: rtl/grid_clear_ctrl_pkg.sv
// grid_pkg: shared geometry, state encoding and row slice positions for the
// 4x3 occupancy grid. Row 0 is the top row and sits in the low nibble.
package grid_pkg;

  localparam int ROWS   = 3;
  localparam int COLS   = 4;
  localparam int GRID_W = ROWS * COLS;

  // Bit offset of each row inside the flat grid vector
  localparam int ROW0_LSB = 0;
  localparam int ROW1_LSB = COLS;
  localparam int ROW2_LSB = 2 * COLS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/grid_clear_ctrl_row_full_detect.sv
// row_full_detect: combinational full-row finder.
//   ain [11:0] : grid contents (row 0 = [3:0], row 2 = [11:8])
//   f   [2:0]  : one-hot full row, top row has priority; 000 when none full
module row_full_detect
  import grid_pkg::*;
(
  input  logic [GRID_W-1:0] ain,
  output logic [ROWS-1:0]   f
);

  always_comb begin
    f = '0;
    if (&ain[ROW0_LSB +: COLS])      f = 3'b001;
    else if (&ain[ROW1_LSB +: COLS]) f = 3'b010;
    else if (&ain[ROW2_LSB +: COLS]) f = 3'b100;
  end

endmodule

// File: rtl/grid_clear_ctrl.sv
// grid_clear_ctrl: sole owner of the 4x3 occupancy grid. Accepts placements
// over valid/ready, rejects overlapping masks, then removes full rows one at
// a time (top row first), collapsing the rows above each removed row.
//   clk, reset     : clock, synchronous active-high reset
//   place_valid    : placement request
//   place_mask     : cells to occupy, same layout as grid
//   place_ready    : high only in IDLE
//   grid           : current occupancy (row 0 top = [3:0])
//   collision      : one-cycle pulse, accepted mask overlapped the grid
//   done           : one-cycle pulse, placement and all clears finished
//   cleared_count  : rows removed by the last completed placement
//   score          : saturating total of rows cleared since reset
module grid_clear_ctrl
  import grid_pkg::*;
#(
  parameter int SCORE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                place_valid,
  input  logic [GRID_W-1:0]   place_mask,
  output logic                place_ready,
  output logic [GRID_W-1:0]   grid,
  output logic                collision,
  output logic                done,
  output logic [1:0]          cleared_count,
  output logic [SCORE_W-1:0]  score
);

  state_t              state, state_n;
  logic [ROWS-1:0]     f;
  logic [ROWS-1:0]     flat;
  logic [1:0]          count;
  logic [GRID_W-1:0]   grid_clr;
  logic [SCORE_W:0]    score_sum;
  logic                accept;

  row_full_detect u_detect (
    .ain (grid),
    .f   (f)
  );

  assign place_ready = (state == IDLE);
  assign accept      = place_valid && place_ready;
  assign score_sum   = {1'b0, score} + (SCORE_W + 1)'(count);

  // Drop the latched row: rows below it keep their place, rows above move
  // down by one, and the top row is refilled with zeros.
  always_comb begin
    grid_clr = grid;
    unique case (flat)
      3'b001:  grid_clr = {grid[ROW2_LSB +: COLS], grid[ROW1_LSB +: COLS], 4'h0};
      3'b010:  grid_clr = {grid[ROW2_LSB +: COLS], grid[ROW0_LSB +: COLS], 4'h0};
      3'b100:  grid_clr = {grid[ROW1_LSB +: COLS], grid[ROW0_LSB +: COLS], 4'h0};
      default: grid_clr = grid;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept && ((place_mask & grid) == '0)) state_n = CHECK;
      CHECK:   state_n = (f != '0) ? CLEAR : DONE;
      CLEAR:   state_n = CHECK;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // done, cleared_count and score are loaded on the CHECK->DONE edge so the
  // registered values coincide with the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      grid          <= '0;
      flat          <= '0;
      count         <= '0;
      score         <= '0;
      cleared_count <= '0;
      done          <= 1'b0;
      collision     <= 1'b0;
    end else begin
      state     <= state_n;
      done      <= 1'b0;
      collision <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if ((place_mask & grid) != '0) begin
              collision <= 1'b1;
            end else begin
              grid  <= grid | place_mask;
              count <= '0;
            end
          end
        end
        CHECK: begin
          if (f != '0) begin
            flat <= f;
          end else begin
            done          <= 1'b1;
            cleared_count <= count;
            score         <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          end
        end
        CLEAR: begin
          grid  <= grid_clr;
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_clear_ctrl.sv
// Bench for grid_clear_ctrl: directed scenarios followed by randomized
// placements, checked against a row-list reference model. Two instances
// share all inputs; the second has a 2-bit score to exercise saturation.
module tb_grid_clear_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        place_valid = 1'b0;
  logic [11:0] place_mask = '0;

  logic        ready8, ready2, coll8, coll2, done8, done2;
  logic [11:0] grid8, grid2;
  logic [1:0]  cc8, cc2;
  logic [7:0]  score8;
  logic [1:0]  score2;

  int errors = 0;
  int checks = 0;

  // model state
  logic [11:0] mgrid = '0;
  int          mtotal = 0;
  int          mcc = 0;

  always #5 clk = ~clk;

  grid_clear_ctrl #(.SCORE_W(8)) dut8 (
    .clk(clk), .reset(reset), .place_valid(place_valid), .place_mask(place_mask),
    .place_ready(ready8), .grid(grid8), .collision(coll8), .done(done8),
    .cleared_count(cc8), .score(score8)
  );

  grid_clear_ctrl #(.SCORE_W(2)) dut2 (
    .clk(clk), .reset(reset), .place_valid(place_valid), .place_mask(place_mask),
    .place_ready(ready2), .grid(grid2), .collision(coll2), .done(done2),
    .cleared_count(cc2), .score(score2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Remove every full row and let the surviving rows settle at the bottom
  // in their original order.
  task automatic model_clear(input logic [11:0] g, output logic [11:0] res, output int n);
    logic [3:0] rows [3];
    logic [3:0] kept [$];
    n = 0;
    for (int r = 0; r < 3; r++) rows[r] = 4'((g >> (4 * r)) & 12'hF);
    for (int r = 0; r < 3; r++) begin
      if (rows[r] == 4'hF) n++;
      else kept.push_back(rows[r]);
    end
    res = '0;
    // kept[] is top-to-bottom; place the last one in row 2, and so on upward
    for (int k = 0; k < kept.size(); k++)
      res = res | (12'(kept[k]) << (4 * (3 - kept.size() + k)));
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_idle_regs(input string tag);
    chk({tag, "_grid8"}, grid8, mgrid);
    chk({tag, "_grid2"}, grid2, mgrid);
    chk({tag, "_ready"}, ready8, 1);
    chk({tag, "_done"}, done8, 0);
    chk({tag, "_coll"}, coll8, 0);
    chk({tag, "_score8"}, score8, sat(mtotal, 255));
    chk({tag, "_score2"}, score2, sat(mtotal, 3));
    chk({tag, "_cc"}, cc8, mcc);
  endtask

  // Called at a negedge while idle. Drives one request, follows it to
  // completion while injecting ignored requests during busy cycles.
  task automatic do_place(input logic [11:0] m, input string tag);
    logic [11:0] res;
    int          n, dcyc;
    chk({tag, "_ready_pre"}, ready8, 1);
    place_valid = 1'b1;
    place_mask  = m;
    @(negedge clk);  // cycle 1
    place_valid = 1'b0;
    if ((m & mgrid) != 0) begin
      chk({tag, "_collision"}, coll8, 1);
      chk({tag, "_coll_grid"}, grid8, mgrid);
      chk({tag, "_coll_done"}, done8, 0);
      chk({tag, "_coll_ready"}, ready8, 1);
      @(negedge clk);
      chk({tag, "_coll_clr"}, coll8, 0);
      chk({tag, "_coll_done2"}, done8, 0);
      chk({tag, "_coll_score"}, score8, sat(mtotal, 255));
    end else begin
      model_clear(mgrid | m, res, n);
      dcyc = 2 + 2 * n;
      chk({tag, "_merge"}, grid8, mgrid | m);
      for (int cyc = 1; cyc <= dcyc + 1; cyc++) begin
        if (cyc > 1) @(negedge clk);
        chk({tag, "_done_t"}, done8, (cyc == dcyc) ? 1 : 0);
        chk({tag, "_ready_t"}, ready8, (cyc == dcyc + 1) ? 1 : 0);
        chk({tag, "_coll_t"}, coll8, 0);
        if (cyc == dcyc) begin
          mgrid  = res;
          mtotal = mtotal + n;
          mcc    = n;
          chk({tag, "_grid"}, grid8, mgrid);
          chk({tag, "_cc"}, cc8, mcc);
          chk({tag, "_score8"}, score8, sat(mtotal, 255));
          chk({tag, "_score2"}, score2, sat(mtotal, 3));
          chk({tag, "_done2"}, done2, 1);
        end
        if (cyc <= dcyc) begin
          place_valid = 1'($urandom);
          place_mask  = 12'($urandom);
        end
      end
      place_valid = 1'b0;
      chk({tag, "_post_grid"}, grid8, mgrid);
    end
  endtask

  initial begin
    logic [11:0] m;
    int          sel;

    // reset for two cycles
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_idle_regs("reset");

    do_place(12'h00F, "top_row");
    do_place(12'h5A3, "p5a3");
    do_place(12'h050, "p050");
    chk("p050_grid_exact", grid8, 12'h530);
    do_place(12'h010, "overlap");
    chk("overlap_grid_exact", grid8, 12'h530);

    // clear the grid so FF0 goes into an empty grid
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mgrid = '0; mtotal = 0; mcc = 0;
    check_idle_regs("rst2");

    do_place(12'hFF0, "two_rows");
    do_place(12'hFFF, "three_rows");   // worst case, score2 saturates
    chk("sat_score2", score2, 2'd3);

    // reset in the first CLEAR cycle aborts the placement
    place_valid = 1'b1;
    place_mask  = 12'hFF0;
    @(negedge clk);  // CHECK
    place_valid = 1'b0;
    @(negedge clk);  // CLEAR
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mgrid = '0; mtotal = 0; mcc = 0;
    check_idle_regs("abort");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_done", done8, 0);
    end

    // simultaneous reset and accept: mask discarded
    do_place(12'h00F, "pre_sim");
    reset       = 1'b1;
    place_valid = 1'b1;
    place_mask  = 12'h0F0;
    @(negedge clk);
    reset       = 1'b0;
    place_valid = 1'b0;
    mgrid = '0; mtotal = 0; mcc = 0;
    check_idle_regs("sim_rst");
    @(negedge clk);
    chk("sim_rst_no_done", done8, 0);
    chk("sim_rst_grid", grid8, 12'h000);

    // randomized placements
    for (int t = 0; t < 80; t++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       m = 12'($urandom);
        1:       m = ~mgrid & 12'($urandom);
        2:       m = ~mgrid & (12'hF << (4 * $urandom_range(0, 2)));
        default: m = ~mgrid;
      endcase
      do_place(m, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
